// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multi-cycle MIPS core: sequences ALU, memory, PC, IR and register file.
// Optional addi support: define MULTI_CYCLE_CTRL_ADDI_EN to add the ADDIEX/ADDIWB states.
module mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_write_s, ir_write_s, mem_write_s, reg_write_s, done_s, illegal_s;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        done_s      = 1'b0;
        illegal_s   = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_op      = 2'b00;
        case (state_q)
            S_FETCH: begin
                state_d    = S_DECODE;
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = 2'b01;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                        done_s    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
                done_s      = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_s = 1'b1;
                done_s      = 1'b1;
            end
            S_RTEX: begin
                state_d   = S_RTWB;
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RTWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
                done_s      = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
                done_s    = 1'b1;
            end
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
            S_ADDIEX: begin
                state_d   = S_ADDIWB;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
`endif
            S_JEX: begin
                pc_write_s = 1'b1;
                pc_src     = 2'b10;
                done_s     = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_control = 3'b010;
        case (alu_op)
            2'b00: alu_control = 3'b010;
            2'b01: alu_control = 3'b110;
            default: begin
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
        endcase
    end

    // Reset masks every write enable so an abandoned instruction cannot commit anything.
    assign pc_write   = pc_write_s & ~reset;
    assign pc_en      = (pc_write_s | (branch & zero)) & ~reset;
    assign ir_write   = ir_write_s & ~reset;
    assign mem_write  = mem_write_s & ~reset;
    assign reg_write  = reg_write_s & ~reset;
    assign instr_done = done_s & ~reset;
    assign illegal_op = illegal_s & ~reset;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm against a path/table reference model.
module tb_mc_control_fsm;

    typedef logic [22:0] vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pc_en, pc_write, branch, iord, mem_write, ir_write, mem_to_reg, reg_dst;
    logic       reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   stim_done = 1'b0;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .pc_write(pc_write), .branch(branch), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [5:0] o);
        bit addi_ok;
`ifdef MULTI_CYCLE_CTRL_ADDI_EN
        addi_ok = 1'b1;
`else
        addi_ok = 1'b0;
`endif
        return (o == 6'd0) || (o == 6'd35) || (o == 6'd43) || (o == 6'd4) ||
               (o == 6'd2) || (addi_ok && o == 6'd8);
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'd32:   return 3'b010;
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd42:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected outputs for one cycle, straight from the per-state output table.
    function automatic vec_t model(input int st, input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input logic r);
        logic pcw = 0, br = 0, io = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
        logic done = 0, ill = 0, pce;
        logic [1:0] sb = 0, ps = 0;
        logic [2:0] ac = 3'b010;
        case (st)
            0:  begin irw = 1; pcw = 1; sb = 2'b01; end
            1:  begin sb = 2'b11; ill = !is_legal(o); done = ill; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin io = 1; mw = 1; done = 1; end
            6:  begin sa = 1; ac = rtype_alu(f); end
            7:  begin rw = 1; rd = 1; done = 1; end
            8:  begin sa = 1; ac = 3'b110; br = 1; ps = 2'b01; done = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; done = 1; end
            11: begin pcw = 1; ps = 2'b10; done = 1; end
            default: ;
        endcase
        pce = pcw | (br & z);
        if (r) begin
            pce = 0; pcw = 0; irw = 0; mw = 0; rw = 0; done = 0; ill = 0;
        end
        return {4'(st), pce, pcw, br, io, mw, irw, m2r, rd, rw, sa, sb, ps, ac, done, ill};
    endfunction

    task automatic cycle(input logic r, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input int st);
        @(posedge clk);
        #1;
        reset = r; op = o; funct = f; zero = z;
        exp_q.push_back(model(st, o, f, z, r));
    endtask

    // One instruction from FETCH; optionally reset at step rst_step for rst_len cycles.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int rst_step, input int rst_len);
        int path[$];
        logic z;
        path = '{0, 1};
        if (is_legal(o)) begin
            case (o)
                6'd0:    path = '{0, 1, 6, 7};
                6'd35:   path = '{0, 1, 2, 3, 4};
                6'd43:   path = '{0, 1, 2, 5};
                6'd4:    path = '{0, 1, 8};
                6'd8:    path = '{0, 1, 9, 10};
                default: path = '{0, 1, 11};
            endcase
        end
        foreach (path[k]) begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (k == rst_step) begin
                cycle(1'b1, o, f, z, path[k]);
                if (rst_len > 1) cycle(1'b1, o, f, z, 0);
                return;
            end
            cycle(1'b0, o, f, z, path[k]);
        end
    endtask

    initial begin
        logic [5:0] o, f;
        int kind, rs, rl;
        logic [5:0] functs[5];
        functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        cycle(1'b1, 6'd0, 6'd0, 1'b0, 0);
        run_instr(6'd0, 6'd42, 2, 2, 2);
        run_instr(6'd35, 6'd0, 2, -1, 0);
        run_instr(6'd0, 6'd42, 2, -1, 0);
        run_instr(6'd4, 6'd0, 1, -1, 0);
        run_instr(6'd4, 6'd0, 0, -1, 0);
        run_instr(6'd63, 6'd0, 2, -1, 0);
        run_instr(6'd8, 6'd5, 2, -1, 0);
        run_instr(6'd43, 6'd0, 2, -1, 0);
        run_instr(6'd2, 6'd0, 2, -1, 0);
        run_instr(6'd35, 6'd0, 2, 4, 1);
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0: o = 6'd0;
                1: o = 6'd35;
                2: o = 6'd43;
                3: o = 6'd4;
                4: o = 6'd8;
                5: o = 6'd2;
                default: o = 6'($urandom_range(0, 63));
            endcase
            f = ($urandom_range(0, 1) == 1) ? functs[$urandom_range(0, 4)]
                                           : 6'($urandom_range(0, 63));
            rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            rl = int'($urandom_range(1, 2));
            run_instr(o, f, 2, rs, rl);
        end
        @(posedge clk);
        stim_done = 1'b1;
    end

    always @(negedge clk) begin
        vec_t got, exp;
        cyc <= cyc + 1;
        got = {state, pc_en, pc_write, branch, iord, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op};
        if (reset === 1'b1) begin
            if ({pc_en, pc_write, ir_write, mem_write, reg_write, instr_done, illegal_op} !== 7'b0) begin
                bad++;
                $display("FAIL reset mask cyc=%0d vec=%h", cyc, got);
            end
        end
        if (illegal_op === 1'b1 && state !== 4'd1) begin
            bad++;
            $display("FAIL illegal_op outside DECODE cyc=%0d state=%0d", cyc, state);
        end
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL outputs cyc=%0d got state=%0d vec=%h required state=%0d vec=%h",
                         cyc, got[22:19], got, exp[22:19], exp);
            end
        end else if (stim_done) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule
